// File: rtl/mc_mips_core.sv
// Multicycle MIPS-subset core: PC, IR, A/B/ALUOut/MDR, 32x32 regfile, ALU and control FSM.
// Latency: R/addi 4, lw 5, sw 4, beq/bne/j 3, exception 4 cycles, plus one per memory wait cycle.
// Backpressure: mem_req and its address/data are held until mem_ready; the FSM stalls in place meanwhile.
module mc_mips_core #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 'h0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        state_out,
    output logic              exc_taken,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] epc_out,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
        S_MEMADDR = 4'd4,  S_MEMRD  = 4'd5,  S_MEMWR  = 4'd6,  S_WB_R   = 4'd7,
        S_WB_I    = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_EXCEPT  = 4'd12, S_HALT   = 4'd13
    } state_t;

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] pc, epc;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       rf [0:31];
    logic [1:0]        cause, pend_cause;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, pc_ext, jump_tgt;
    logic [31:0] alu_res;
    logic        alu_ovf, alu_ill, br_taken;

    always_comb begin
        opcode   = ir[31:26];
        rs       = ir[25:21];
        rt       = ir[20:16];
        rd       = ir[15:11];
        funct    = ir[5:0];
        simm     = {{16{ir[15]}}, ir[15:0]};
        pc_ext   = 32'(pc);
        jump_tgt = {pc_ext[31:28], ir[25:0], 2'b00};
        br_taken = (opcode == 6'h04) ? (a == b) : (a != b);
    end

    // Overflow is only meaningful for the legal add/sub/addi cases; illegal wins otherwise.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        if (state == S_EXEC_R) begin
            case (funct)
                6'h20: begin
                    alu_res = a + b;
                    alu_ovf = (a[31] == b[31]) && (alu_res[31] != a[31]);
                end
                6'h22: begin
                    alu_res = a - b;
                    alu_ovf = (a[31] != b[31]) && (alu_res[31] != a[31]);
                end
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h2A:   alu_res = {31'b0, $signed(a) < $signed(b)};
                default: alu_ill = 1'b1;
            endcase
        end else begin
            alu_res = a + simm;
            alu_ovf = (a[31] == simm[31]) && (alu_res[31] != a[31]);
            alu_ill = (opcode != 6'h08);
            if (alu_ill) alu_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:        nxt_state = (funct == 6'h0D) ? S_HALT : S_EXEC_R;
                    6'h23, 6'h2B: nxt_state = S_MEMADDR;
                    6'h04, 6'h05: nxt_state = S_BRANCH;
                    6'h02:        nxt_state = S_JUMP;
                    default:      nxt_state = S_EXEC_I;
                endcase
            end
            S_EXEC_R:  nxt_state = (alu_ill || alu_ovf) ? S_EXCEPT : S_WB_R;
            S_EXEC_I:  nxt_state = (alu_ill || alu_ovf) ? S_EXCEPT : S_WB_I;
            S_MEMADDR: nxt_state = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) nxt_state = S_WB_MEM;
            S_MEMWR:   if (mem_ready) nxt_state = S_FETCH;
            S_HALT:    nxt_state = S_HALT;
            default:   nxt_state = S_FETCH;
        endcase
    end

    // Request is gated by reset so an abandoned write is withdrawn in the reset cycle itself.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        exc_taken = 1'b0;
        halted    = 1'b0;
        case (state)
            S_FETCH:  mem_req = ~reset;
            S_MEMRD: begin
                mem_req  = ~reset;
                mem_addr = ADDR_W'(alu_out);
            end
            S_MEMWR: begin
                mem_req  = ~reset;
                mem_we   = ~reset;
                mem_addr = ADDR_W'(alu_out);
            end
            S_EXCEPT: exc_taken = 1'b1;
            S_HALT:   halted    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            epc        <= '0;
            cause      <= '0;
            pend_cause <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + ADDR_W'(4);
                end
                S_DECODE: begin
                    a       <= (rs == 5'd0) ? 32'd0 : rf[rs];
                    b       <= (rt == 5'd0) ? 32'd0 : rf[rt];
                    alu_out <= pc_ext + (simm << 2);
                end
                S_EXEC_R, S_EXEC_I: begin
                    alu_out    <= alu_res;
                    pend_cause <= alu_ill ? 2'd2 : (alu_ovf ? 2'd1 : 2'd0);
                end
                S_MEMADDR: alu_out <= a + simm;
                S_MEMRD:   if (mem_ready) mdr <= mem_rdata;
                S_WB_R:    if (rd != 5'd0) rf[rd] <= alu_out;
                S_WB_I:    if (rt != 5'd0) rf[rt] <= alu_out;
                S_WB_MEM:  if (rt != 5'd0) rf[rt] <= mdr;
                S_BRANCH:  if (br_taken) pc <= ADDR_W'(alu_out);
                S_JUMP:    pc <= ADDR_W'(jump_tgt);
                S_EXCEPT: begin
                    epc   <= pc - ADDR_W'(4);
                    cause <= pend_cause;
                    pc    <= EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = b;
    assign pc_out    = pc;
    assign state_out = state;
    assign exc_cause = cause;
    assign epc_out   = epc;

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed programs on a wait-state memory model; completed stores are checked against a queue.
module tb_mc_mips_core;

    localparam logic [3:0] S_FETCH = 4'd0, S_MEMWR = 4'd6, S_WB_R = 4'd7, S_EXCEPT = 4'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc_out, epc_out;
    logic [3:0]  state_out;
    logic        exc_taken, halted;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    mc_mips_core dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .state_out(state_out),
        .exc_taken(exc_taken), .exc_cause(exc_cause), .epc_out(epc_out), .halted(halted)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] mem [0:255];
    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          wait_n = 0;
    int          wcnt   = 0;
    logic        rdy_was = 1'b0, req_was = 1'b0, we_was = 1'b0, rst_was = 1'b1;
    logic [31:0] addr_was = '0, wdata_was = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: responds after wait_n wait cycles; a write lands when req&ready was seen at an edge.
    always @(negedge clk) begin
        wr_t e;
        if (rdy_was && req_was && !rst_was) begin
            if (we_was) begin
                mem[addr_was[9:2]] = wdata_was;
                check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", addr_was, e.addr);
                    check("wr_data", wdata_was, e.data);
                end
            end
            wcnt = 0;
        end
        req_was   = mem_req;
        we_was    = mem_we;
        addr_was  = mem_addr;
        wdata_was = mem_wdata;
        rst_was   = reset;
        if (mem_req) begin
            if (wcnt >= wait_n) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
        rdy_was = mem_ready;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    initial begin
        logic found;
        logic [31:0] brk;
        brk   = enc_r(5'd0, 5'd0, 5'd0, 6'h0D);
        reset = 1'b1;

        // Program 1: arithmetic, stores/loads with waits, branches, jump, break
        clear_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(32'h0C, enc_i(6'h2B, 5'd0, 5'd3, 16'h40));
        put(32'h10, enc_i(6'h2B, 5'd0, 5'd3, 16'h10));
        put(32'h14, enc_i(6'h23, 5'd0, 5'd4, 16'h10));
        put(32'h18, enc_i(6'h2B, 5'd0, 5'd4, 16'h44));
        put(32'h1C, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(32'h20, brk);
        put(32'h24, brk);
        put(32'h28, enc_i(6'h05, 5'd1, 5'd1, 16'd2));
        put(32'h2C, {6'h02, 26'd13});
        put(32'h30, brk);
        put(32'h34, brk);
        exp_q.push_back('{addr: 32'h40, data: 32'd12});
        exp_q.push_back('{addr: 32'h10, data: 32'd12});
        exp_q.push_back('{addr: 32'h44, data: 32'd12});

        repeat (3) tick();
        check("rst_pc", pc_out, 32'h0);
        check("rst_state", 32'(state_out), 32'(S_FETCH));
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_exc_taken", 32'(exc_taken), 32'd0);
        check("rst_exc_cause", 32'(exc_cause), 32'd0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        repeat (11) tick();
        check("add_in_wb", 32'(state_out), 32'(S_WB_R));
        tick();
        check("arith_12cyc_pc", pc_out, 32'd12);
        check("arith_12cyc_state", 32'(state_out), 32'(S_FETCH));
        repeat (4) tick();
        check("sw0_pc", pc_out, 32'd16);
        wait_n = 2;
        repeat (7) tick();
        check("sw_wait_in_memwr", 32'(state_out), 32'(S_MEMWR));
        tick();
        check("sw_wait_8cyc_pc", pc_out, 32'd20);
        check("sw_wait_8cyc_state", 32'(state_out), 32'(S_FETCH));
        repeat (9) tick();
        check("lw_wait_9cyc_pc", pc_out, 32'd24);
        check("lw_wait_9cyc_state", 32'(state_out), 32'(S_FETCH));
        repeat (8) tick();
        check("sw2_pc", pc_out, 32'd28);
        wait_n = 0;
        check("mem_word4", mem[4], 32'd12);
        repeat (3) tick();
        check("beq_taken_pc", pc_out, 32'd40);
        repeat (3) tick();
        check("bne_not_taken_pc", pc_out, 32'd44);
        repeat (3) tick();
        check("jump_pc", pc_out, 32'd52);
        repeat (2) tick();
        check("break_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_no_req", 32'(mem_req), 32'd0);
        end
        check("halt_still", 32'(halted), 32'd1);
        check("prog1_writes_done", 32'(exp_q.size()), 32'd0);

        // Program 2: overflow then illegal opcode, handler counts visits in $8
        reset = 1'b1;
        clear_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd9, 16'd1));
        put(32'h04, enc_i(6'h23, 5'd0, 5'd5, 16'h48));
        put(32'h08, enc_r(5'd5, 5'd5, 5'd6, 6'h20));
        put(32'h48, 32'h7FFF_FFFF);
        put(32'h80, enc_i(6'h08, 5'd8, 5'd8, 16'd1));
        put(32'h84, enc_i(6'h05, 5'd8, 5'd9, 16'd6));
        put(32'h88, enc_i(6'h2B, 5'd0, 5'd6, 16'h4C));
        put(32'h8C, 32'hFC00_0000);
        put(32'hA0, brk);
        exp_q.push_back('{addr: 32'h4C, data: 32'd0});
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        check("ovf_except_state", 32'(state_out), 32'(S_EXCEPT));
        check("ovf_exc_pulse", 32'(exc_taken), 32'd1);
        tick();
        check("ovf_pulse_end", 32'(exc_taken), 32'd0);
        check("ovf_cause", 32'(exc_cause), 32'd1);
        check("ovf_epc", epc_out, 32'h8);
        check("ovf_vector_pc", pc_out, 32'h80);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (exc_taken) found = 1'b1;
        end
        check("ill_exc_seen", 32'(found), 32'd1);
        tick();
        check("ill_cause", 32'(exc_cause), 32'd2);
        check("ill_epc", epc_out, 32'h8C);
        check("ill_vector_pc", pc_out, 32'h80);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (halted) found = 1'b1;
        end
        check("handler_halted", 32'(found), 32'd1);
        check("handler_halt_pc", pc_out, 32'hA4);
        check("prog2_writes_done", 32'(exp_q.size()), 32'd0);

        // Program 3: reset while a store waits
        reset = 1'b1;
        clear_mem();
        put(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'h55));
        put(32'h04, enc_i(6'h2B, 5'd0, 5'd1, 16'h50));
        put(32'h50, 32'h0000_DEAD);
        wait_n = 5;
        repeat (2) tick();
        check("rst2_exc_cause", 32'(exc_cause), 32'd0);
        check("rst2_epc", epc_out, 32'h0);
        check("rst2_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (state_out == S_MEMWR) found = 1'b1;
        end
        check("memwr_reached", 32'(found), 32'd1);
        tick();
        check("memwr_hold_req", 32'(mem_req), 32'd1);
        check("memwr_hold_we", 32'(mem_we), 32'd1);
        check("memwr_hold_addr", mem_addr, 32'h50);
        check("memwr_hold_data", mem_wdata, 32'h55);
        reset = 1'b1;
        tick();
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_pc", pc_out, 32'h0);
        check("abort_state", 32'(state_out), 32'(S_FETCH));
        repeat (2) tick();
        check("abort_mem_unchanged", mem[20], 32'h0000_DEAD);
        check("abort_no_writes", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
